// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receive FSM states, word/channel width helpers and clogb2,
// used by both the receive deserialiser and the transmit stage.
package i2s_pkg;

  typedef enum logic [2:0] {
    SYNC,
    L_SHIFT,
    L_WAIT,
    R_SHIFT,
    DONE,
    R_WAIT
  } rcv_state_t;

  localparam int DEF_DATA_BITS = 32;

  // Counter width able to hold value-1; never narrower than one bit.
  function automatic int clogb2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int nb_of(input int data_bits);
    return data_bits / 2;
  endfunction

  function automatic int ns_of(input int data_bits);
    return clogb2(data_bits / 2);
  endfunction

endpackage

// File: rtl/i2s_shift_in.sv
// Per-channel serial capture: NB-bit MSB-first shift register plus a down-counting bit
// counter whose terminal count (last) marks the channel LSB.
module i2s_shift_in
  import i2s_pkg::*;
#(
  parameter int NB = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          shift,
  input  logic          din,
  output logic [NB-1:0] data,
  output logic          last
);

  localparam int NS = clogb2(NB);

  logic [NS-1:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      data    <= '0;
      bit_cnt <= NS'(NB - 1);
    end else if (shift) begin
      data <= {data[NB-2:0], din};
      if (bit_cnt != '0) bit_cnt <= bit_cnt - NS'(1);
    end
  end

  assign last = (bit_cnt == '0);

endmodule

// File: rtl/i2s_rcv_deser.sv
// I2S receive deserialiser: frames the codec ADC line with lrclk on CBrise strobes and
// hands one {left,right} word per lrclk period downstream over rcv_rdy/rcv_ack.
//
// state   | meaning
// SYNC    | waiting for an lrclk fall before trusting any data
// L_SHIFT | capturing left-channel bits, MSB first
// L_WAIT  | left slot padding; waiting for lrclk rise
// R_SHIFT | capturing right-channel bits, MSB first
// DONE    | one clk: publish {left,right} to sample
// R_WAIT  | right slot padding; waiting for lrclk fall
module i2s_rcv_deser
  import i2s_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lrclk,
  input  logic                 CBrise,
  input  logic                 din,
  output logic [DATA_BITS-1:0] sample,
  output logic                 rcv_rdy,
  input  logic                 rcv_ack,
  output logic                 overrun,
  output logic                 frame_err
);

  localparam int NB = nb_of(DATA_BITS);

  rcv_state_t    state, state_nxt;
  logic          lr_prev;
  logic          fall, rise;
  logic          sh_load, sh_shift, sh_last;
  logic          cap_left, load_out, err;
  logic [NB-1:0] sh_data;
  logic [NB-1:0] left_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lr_prev <= 1'b1;
    else if (CBrise) lr_prev <= lrclk;
  end

  // The edge-detecting strobe is the I2S one-bit delay; shifting starts on the next strobe.
  assign fall = CBrise & lr_prev & ~lrclk;
  assign rise = CBrise & ~lr_prev & lrclk;

  i2s_shift_in #(.NB(NB)) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (din),
    .data  (sh_data),
    .last  (sh_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SYNC;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SYNC:    if (fall) state_nxt = L_SHIFT;
      L_SHIFT: if (rise) state_nxt = SYNC;
               else if (CBrise && sh_last) state_nxt = L_WAIT;
      L_WAIT:  if (rise) state_nxt = R_SHIFT;
      R_SHIFT: if (fall) state_nxt = SYNC;
               else if (CBrise && sh_last) state_nxt = DONE;
      DONE:    state_nxt = R_WAIT;
      R_WAIT:  if (fall) state_nxt = L_SHIFT;
      default: state_nxt = SYNC;
    endcase
  end

  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    cap_left = 1'b0;
    load_out = 1'b0;
    err      = 1'b0;
    unique case (state)
      SYNC, R_WAIT: sh_load = fall;
      L_SHIFT: begin
        err      = rise;
        sh_shift = CBrise & ~rise;
        cap_left = CBrise & ~rise & sh_last;
      end
      L_WAIT:  sh_load = rise;
      R_SHIFT: begin
        err      = fall;
        sh_shift = CBrise & ~fall;
      end
      DONE:    load_out = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) left_reg <= '0;
    else if (cap_left) left_reg <= {sh_data[NB-2:0], din};
  end

  // A new word always wins over a pending ack; overrun only when the old word was never taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample    <= '0;
      rcv_rdy   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err;
      overrun   <= load_out & rcv_rdy & ~rcv_ack;
      if (load_out) begin
        sample  <= {left_reg, sh_data};
        rcv_rdy <= 1'b1;
      end else if (rcv_ack) begin
        rcv_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rcv_deser.sv
// Scoreboard bench for i2s_rcv_deser: serial frames are generated at BCLK granularity,
// expected words/errors are queued with their due clk and checked by a cycle monitor.
module tb_i2s_rcv_deser;

  localparam int DB = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lrclk;
  logic          CBrise;
  logic          din;
  logic [DB-1:0] sample;
  logic          rcv_rdy;
  logic          rcv_ack;
  logic          overrun;
  logic          frame_err;

  typedef struct {
    logic [31:0] word;
    int          due;
  } exp_t;

  exp_t word_q[$];
  int   err_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   ack_mode = 0;
  bit   ack_req = 1'b0;

  i2s_rcv_deser #(.DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lrclk     (lrclk),
    .CBrise    (CBrise),
    .din       (din),
    .sample    (sample),
    .rcv_rdy   (rcv_rdy),
    .rcv_ack   (rcv_ack),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic rb();
    return ($urandom_range(0, 1) == 1);
  endfunction

  // Downstream consumer: random acks (mode 0) or only explicit pulses (mode 1).
  initial begin
    rcv_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ack_mode == 0) rcv_ack = ack_req | ($urandom_range(0, 3) == 0);
      else rcv_ack = ack_req;
    end
  end

  // One BCLK period = 4 clk with CBrise on the first. Entered and left at posedge+1.
  task automatic tick(input logic lr, input logic d, input bit ack_done = 1'b0,
                      input bit push_w = 1'b0, input logic [31:0] w = '0,
                      input bit push_e = 1'b0);
    int c;
    lrclk  = lr;
    din    = d;
    CBrise = 1'b1;
    @(posedge clk);
    #1;
    c       = cyc;
    CBrise  = 1'b0;
    ack_req = ack_done;
    if (push_w) word_q.push_back('{word: w, due: c + 1});
    if (push_e) err_q.push_back(c);
    @(posedge clk);
    #1;
    ack_req = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full 64-BCLK frame; channel MSB follows the edge strobe by one BCLK.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit ack_done);
    logic [31:0] w;
    w = {l, r};
    tick(1'b0, rb());
    for (int i = 15; i >= 0; i--) tick(1'b0, l[i]);
    repeat (15) tick(1'b0, rb());
    tick(1'b1, rb());
    for (int i = 15; i >= 1; i--) tick(1'b1, r[i]);
    tick(1'b1, r[0], ack_done, 1'b1, w);
    repeat (15) tick(1'b1, rb());
  endtask

  task automatic send_left_err(input int nbits);
    tick(1'b0, rb());
    repeat (nbits) tick(1'b0, rb());
    tick(1'b1, rb(), 1'b0, 1'b0, '0, 1'b1);
    repeat (40) tick(1'b1, rb());
  endtask

  task automatic send_right_err(input int nbits);
    tick(1'b0, rb());
    repeat (31) tick(1'b0, rb());
    tick(1'b1, rb());
    repeat (nbits) tick(1'b1, rb());
    tick(1'b0, rb(), 1'b0, 1'b0, '0, 1'b1);
    repeat (20) tick(1'b0, rb());
    repeat (32) tick(1'b1, rb());
  endtask

  task automatic send_abort(input int nbits);
    tick(1'b0, rb());
    repeat (31) tick(1'b0, rb());
    tick(1'b1, rb());
    repeat (nbits) tick(1'b1, rb());
    chk1("rdy_before_reset", rcv_rdy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_rdy", rcv_rdy, 1'b0);
    chk32("async_rst_sample", sample, 32'h0);
    chk1("async_rst_overrun", overrun, 1'b0);
    chk1("async_rst_frame_err", frame_err, 1'b0);
    repeat (3) tick(1'b1, rb());
    rst_n = 1'b1;
    repeat (10) tick(1'b1, rb());
  endtask

  // Monitor: a word is valid from its due clk until acked or replaced.
  initial begin
    logic        m_rdy;
    logic [31:0] m_sample;
    logic        ack_prev;
    logic        exp_over;
    logic        exp_err;
    int          n;
    m_rdy    = 1'b0;
    m_sample = '0;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_rdy    = 1'b0;
        m_sample = '0;
        word_q.delete();
        err_q.delete();
        chk1("rst_rdy", rcv_rdy, 1'b0);
        chk32("rst_sample", sample, 32'h0);
        chk1("rst_overrun", overrun, 1'b0);
        chk1("rst_frame_err", frame_err, 1'b0);
      end else begin
        n        = cyc;
        exp_over = 1'b0;
        exp_err  = 1'b0;
        if (word_q.size() > 0 && word_q[0].due == n) begin
          exp_over = m_rdy & ~ack_prev;
          m_rdy    = 1'b1;
          m_sample = word_q[0].word;
          void'(word_q.pop_front());
        end else if (ack_prev && m_rdy) begin
          m_rdy = 1'b0;
        end
        if (err_q.size() > 0 && err_q[0] == n) begin
          exp_err = 1'b1;
          void'(err_q.pop_front());
        end
        chk1("rcv_rdy", rcv_rdy, m_rdy);
        chk32("sample", sample, m_sample);
        chk1("overrun", overrun, exp_over);
        chk1("frame_err", frame_err, exp_err);
      end
      ack_prev = rcv_ack;
    end
  end

  initial begin
    rst_n  = 1'b0;
    lrclk  = 1'b1;
    din    = 1'b0;
    CBrise = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // join mid right channel: nothing until the first fall
    repeat (12) tick(1'b1, rb());
    send_frame(16'hA5C3, 16'h1234, 1'b0);

    ack_mode = 1;
    send_frame(16'($urandom), 16'($urandom), 1'b0);
    send_frame(16'hFFFF, 16'h0001, 1'b0);
    send_frame(16'($urandom), 16'($urandom), 1'b1);
    ack_mode = 0;
    repeat (8) tick(1'b1, rb());

    send_left_err(10);
    send_frame(16'h8001, 16'h7FFE, 1'b0);
    send_right_err(5);

    ack_mode = 1;
    send_frame(16'($urandom), 16'($urandom), 1'b0);
    send_abort(7);
    ack_mode = 0;

    repeat (4) send_frame(16'($urandom), 16'($urandom), 1'b0);

    repeat (20) @(posedge clk);
    #1;
    chk32("words_pending", 32'(word_q.size()), 32'h0);
    chk32("errs_pending", 32'(err_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
